// File: rtl/spill_gate_det.sv
// spill_gate_det: synchronises and debounces the raw beam-spill gate into start/skip/end
// pulses and measures spill length. Optional timeout feature: define SPILL_TIMEOUT_EN.
module spill_gate_det #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LEN_W       = 24
`ifdef SPILL_TIMEOUT_EN
    ,
    parameter logic [LEN_W-1:0] MAX_LEN = '1
`endif
) (
    input  logic             clk,
    input  logic             system_rst,
    input  logic             in_spill_raw,
    input  logic             live_enabled,
    input  logic [7:0]       debounce_len,
    input  logic [15:0]      min_gap,
    output logic             in_spill,
    output logic             spill_start,
    output logic             spill_skip,
    output logic             spill_end,
    output logic [LEN_W-1:0] spill_len,
    output logic             spill_len_valid
`ifdef SPILL_TIMEOUT_EN
    ,
    output logic             spill_timeout
`endif
);

    typedef enum logic [2:0] {IDLE, ON_DB, SPILL, OFF_DB, GAP} state_t;

    state_t                 r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s_in;
    logic [7:0]             w_deb;
    logic [7:0]             r_db_cnt, w_db_nxt;
    logic [8:0]             w_db_inc;
    logic [LEN_W-1:0]       r_len_cnt, w_len_nxt, w_len_inc;
    logic [15:0]            r_gap_cnt, w_gap_nxt;
    logic [LEN_W-1:0]       r_spill_len, w_spill_len_nxt;
    logic                   r_start, w_start_nxt;
    logic                   r_skip, w_skip_nxt;
    logic                   r_end, w_end_nxt;
    logic                   w_accept, w_finish;
`ifdef SPILL_TIMEOUT_EN
    logic                   r_timeout, w_timeout_nxt;
    logic                   r_seen_low, w_seen_low_nxt;
`endif

    always_ff @(posedge clk or posedge system_rst) begin
        if (system_rst) r_sync <= '0;
        else            r_sync <= {r_sync[SYNC_STAGES-2:0], in_spill_raw};
    end

    assign w_s_in    = r_sync[SYNC_STAGES-1];
    assign w_deb     = (debounce_len == 8'd0) ? 8'd1 : debounce_len;
    assign w_db_inc  = {1'b0, r_db_cnt} + 9'd1;
    assign w_len_inc = (&r_len_cnt) ? r_len_cnt : r_len_cnt + LEN_W'(1);

    always_comb begin
        w_state_nxt     = r_state;
        w_db_nxt        = r_db_cnt;
        w_len_nxt       = r_len_cnt;
        w_gap_nxt       = r_gap_cnt;
        w_spill_len_nxt = r_spill_len;
        w_start_nxt     = 1'b0;
        w_skip_nxt      = 1'b0;
        w_end_nxt       = 1'b0;
        w_accept        = 1'b0;
        w_finish        = 1'b0;
`ifdef SPILL_TIMEOUT_EN
        w_timeout_nxt   = 1'b0;
        w_seen_low_nxt  = r_seen_low;
`endif
        case (r_state)
            IDLE: if (w_s_in) begin
                w_db_nxt = 8'd1;
                // A one-cycle debounce accepts straight from IDLE to keep latency = deb.
                if (w_deb == 8'd1) w_accept    = 1'b1;
                else               w_state_nxt = ON_DB;
            end
            ON_DB: begin
                if (!w_s_in) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_db_nxt = w_db_inc[7:0];
                    if (w_db_inc >= {1'b0, w_deb}) w_accept = 1'b1;
                end
            end
            SPILL: begin
                w_len_nxt = w_len_inc;
                if (!w_s_in) begin
                    w_db_nxt = 8'd1;
                    if (w_deb == 8'd1) w_finish    = 1'b1;
                    else               w_state_nxt = OFF_DB;
                end
            end
            OFF_DB: begin
                w_len_nxt = w_len_inc;
                if (w_s_in) begin
                    w_state_nxt = SPILL;
                end else begin
                    w_db_nxt = w_db_inc[7:0];
                    if (w_db_inc >= {1'b0, w_deb}) w_finish = 1'b1;
                end
            end
            GAP: begin
`ifdef SPILL_TIMEOUT_EN
                if (!w_s_in) w_seen_low_nxt = 1'b1;
                if (r_gap_cnt >= min_gap) begin
                    if (r_seen_low || !w_s_in) w_state_nxt = IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt + 16'd1;
                end
`else
                if (r_gap_cnt >= min_gap) w_state_nxt = IDLE;
                else                      w_gap_nxt   = r_gap_cnt + 16'd1;
`endif
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_accept) begin
            w_state_nxt = SPILL;
            w_len_nxt   = LEN_W'(w_deb);
            w_start_nxt = live_enabled;
            w_skip_nxt  = ~live_enabled;
        end
        if (w_finish) begin
            w_state_nxt     = GAP;
            w_gap_nxt       = '0;
            w_end_nxt       = 1'b1;
            w_spill_len_nxt = w_len_inc - LEN_W'(w_deb);
`ifdef SPILL_TIMEOUT_EN
            w_seen_low_nxt  = 1'b1;
`endif
        end
`ifdef SPILL_TIMEOUT_EN
        // Timeout wins over a coincident normal end; GAP then waits for a low level.
        if ((r_state == SPILL || r_state == OFF_DB) && w_len_inc >= MAX_LEN) begin
            w_state_nxt     = GAP;
            w_gap_nxt       = '0;
            w_end_nxt       = 1'b1;
            w_timeout_nxt   = 1'b1;
            w_spill_len_nxt = MAX_LEN;
            w_seen_low_nxt  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge system_rst) begin
        if (system_rst) begin
            r_state     <= IDLE;
            r_db_cnt    <= '0;
            r_len_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_spill_len <= '0;
            r_start     <= 1'b0;
            r_skip      <= 1'b0;
            r_end       <= 1'b0;
`ifdef SPILL_TIMEOUT_EN
            r_timeout   <= 1'b0;
            r_seen_low  <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_db_cnt    <= w_db_nxt;
            r_len_cnt   <= w_len_nxt;
            r_gap_cnt   <= w_gap_nxt;
            r_spill_len <= w_spill_len_nxt;
            r_start     <= w_start_nxt;
            r_skip      <= w_skip_nxt;
            r_end       <= w_end_nxt;
`ifdef SPILL_TIMEOUT_EN
            r_timeout   <= w_timeout_nxt;
            r_seen_low  <= w_seen_low_nxt;
`endif
        end
    end

    assign in_spill        = (r_state == SPILL) || (r_state == OFF_DB);
    assign spill_start     = r_start;
    assign spill_skip      = r_skip;
    assign spill_end       = r_end;
    assign spill_len_valid = r_end;
    assign spill_len       = r_spill_len;
`ifdef SPILL_TIMEOUT_EN
    assign spill_timeout   = r_timeout;
`endif

endmodule

// File: tb/tb_spill_gate_det.sv
// Directed bench for spill_gate_det: timestamp-based spill model checked every cycle,
// plus literal expectations per scenario. Timeout scenario runs when SPILL_TIMEOUT_EN is set.
module tb_spill_gate_det;

    localparam int SYNC = 2;
    localparam int LW   = 24;
`ifdef SPILL_TIMEOUT_EN
    localparam int MAXL = 200;
`endif

    logic          clk = 1'b0;
    logic          rst, raw, live;
    logic [7:0]    dbl;
    logic [15:0]   mg;
    logic          in_spill, spill_start, spill_skip, spill_end, spill_len_valid;
    logic [LW-1:0] spill_len;
`ifdef SPILL_TIMEOUT_EN
    logic          spill_timeout;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spill_gate_det #(
        .SYNC_STAGES(SYNC),
`ifdef SPILL_TIMEOUT_EN
        .MAX_LEN(24'(MAXL)),
`endif
        .LEN_W(LW)
    ) dut (
        .clk(clk),
        .system_rst(rst),
        .in_spill_raw(raw),
        .live_enabled(live),
        .debounce_len(dbl),
        .min_gap(mg),
        .in_spill(in_spill),
        .spill_start(spill_start),
        .spill_skip(spill_skip),
        .spill_end(spill_end),
`ifdef SPILL_TIMEOUT_EN
        .spill_timeout(spill_timeout),
`endif
        .spill_len(spill_len),
        .spill_len_valid(spill_len_valid)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 = waiting for a start, 1 = spill active, 2 = holdoff after end.
    int            cyc = 0;
    int            m_phase = 0, m_hi = 0, m_lo = 0, m_start_t = 0, m_gap_t = 0, m_deb;
    bit            m_need_low = 0;
    logic [SYNC-1:0] m_sh = '0;
    logic          m_s;
    bit            e_start, e_skip, e_end, e_to;
    int            e_len = 0;
    int            n_start = 0, n_skip = 0, n_end = 0, n_to = 0, start_cyc = 0;

    always @(posedge clk) begin
        cyc++;
        e_start = 0; e_skip = 0; e_end = 0; e_to = 0;
        if (rst) begin
            m_sh = '0; m_phase = 0; m_hi = 0; m_lo = 0; e_len = 0; m_need_low = 0;
        end else begin
            m_s   = m_sh[SYNC-1];
            m_sh  = {m_sh[SYNC-2:0], raw};
            m_deb = (dbl == 8'd0) ? 1 : int'(dbl);
            case (m_phase)
                0: begin
                    m_hi = m_s ? m_hi + 1 : 0;
                    if (m_hi >= m_deb) begin
                        m_phase = 1; m_lo = 0;
                        m_start_t = cyc - m_deb + 1;
                        e_start = live; e_skip = !live;
                    end
                end
                1: begin
                    m_lo = m_s ? 0 : m_lo + 1;
                    if (m_lo >= m_deb) begin
                        m_phase = 2; m_gap_t = cyc; e_end = 1; m_need_low = 0;
                        e_len = (cyc - m_deb + 1) - m_start_t;
                    end
`ifdef SPILL_TIMEOUT_EN
                    if (cyc - m_start_t + 1 >= MAXL) begin
                        m_phase = 2; m_gap_t = cyc; e_end = 1; e_to = 1;
                        e_len = MAXL; m_need_low = 1;
                    end
`endif
                end
                default: begin
                    if (!m_s) m_need_low = 0;
                    if (cyc - m_gap_t > int'(mg) && !m_need_low) begin
                        m_phase = 0; m_hi = 0;
                    end
                end
            endcase
        end
        #1;
        chk("in_spill", in_spill, m_phase == 1);
        chk("spill_start", spill_start, e_start);
        chk("spill_skip", spill_skip, e_skip);
        chk("spill_end", spill_end, e_end);
        chk("spill_len_valid", spill_len_valid, e_end);
        chk("spill_len", spill_len, e_len);
`ifdef SPILL_TIMEOUT_EN
        chk("spill_timeout", spill_timeout, e_to);
        if (spill_timeout) n_to++;
`endif
        if (spill_start) begin n_start++; start_cyc = cyc; end
        if (spill_skip) n_skip++;
        if (spill_end) n_end++;
    end

    task automatic wait_end(input int maxc, input string name);
        bit seen = 0;
        for (int k = 0; k < maxc && !seen; k++) begin
            @(posedge clk); #1;
            seen = spill_end;
        end
        chk(name, seen, 1);
    endtask

    int s0, k0, e0, t0, rise;

    initial begin
        rst = 1'b1; raw = 1'b0; live = 1'b1; dbl = 8'd4; mg = 16'd10;
        repeat (3) @(negedge clk);
        chk("rst_in_spill", in_spill, 0);
        chk("rst_len", spill_len, 0);
        chk("rst_pulses", {spill_start, spill_skip, spill_end, spill_len_valid}, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 100-cycle spill, live
        s0 = n_start; e0 = n_end;
        raw = 1'b1; rise = cyc;
        repeat (100) @(negedge clk);
        raw = 1'b0;
        repeat (30) @(negedge clk);
        chk("t1_starts", n_start - s0, 1);
        chk("t1_ends", n_end - e0, 1);
        chk("t1_latency", start_cyc - rise, SYNC + 4);
        chk("t1_len", spill_len, 100);

        // 3-cycle glitch rejected
        s0 = n_start;
        raw = 1'b1;
        repeat (3) @(negedge clk);
        raw = 1'b0;
        repeat (20) @(negedge clk);
        chk("t2_starts", n_start - s0, 0);
        chk("t2_in_spill", in_spill, 0);

        // short dropout absorbed into spill
        s0 = n_start; e0 = n_end;
        raw = 1'b1; repeat (60) @(negedge clk);
        raw = 1'b0; repeat (2)  @(negedge clk);
        raw = 1'b1; repeat (40) @(negedge clk);
        raw = 1'b0; repeat (30) @(negedge clk);
        chk("t3_starts", n_start - s0, 1);
        chk("t3_ends", n_end - e0, 1);
        chk("t3_len", spill_len, 102);

        // not live: skip instead of start
        live = 1'b0;
        s0 = n_start; k0 = n_skip; e0 = n_end;
        raw = 1'b1; repeat (30) @(negedge clk);
        raw = 1'b0; repeat (30) @(negedge clk);
        live = 1'b1;
        chk("t4_starts", n_start - s0, 0);
        chk("t4_skips", n_skip - k0, 1);
        chk("t4_ends", n_end - e0, 1);
        chk("t4_len", spill_len, 30);

        // holdoff of 50 cycles after end
        mg = 16'd50;
        raw = 1'b1; repeat (30) @(negedge clk);
        raw = 1'b0;
        wait_end(40, "t5_first_end");
        s0 = n_start;
        repeat (19) @(negedge clk);
        raw = 1'b1; repeat (10) @(negedge clk);
        raw = 1'b0; repeat (10) @(negedge clk);
        chk("t5_ignored", n_start - s0, 0);
        raw = 1'b1; repeat (80) @(negedge clk);
        raw = 1'b0;
        wait_end(40, "t5_second_end");
        chk("t5_starts", n_start - s0, 1);
        chk("t5_len", spill_len, 69);
        repeat (60) @(negedge clk);
        mg = 16'd10;

        // debounce_len=0 behaves as 1
        dbl = 8'd0;
        raw = 1'b1; rise = cyc;
        repeat (20) @(negedge clk);
        raw = 1'b0; repeat (20) @(negedge clk);
        chk("t6_latency", start_cyc - rise, SYNC + 1);
        chk("t6_len", spill_len, 20);
        dbl = 8'd4;

        // asynchronous reset mid-spill
        raw = 1'b1; repeat (30) @(negedge clk);
        e0 = n_end;
        chk("t7_pre_in_spill", in_spill, 1);
        #2 rst = 1'b1; raw = 1'b0;
        #1;
        chk("t7_in_spill", in_spill, 0);
        chk("t7_len", spill_len, 0);
        chk("t7_pulses", {spill_start, spill_skip, spill_end, spill_len_valid}, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("t7_ends", n_end - e0, 0);

`ifdef SPILL_TIMEOUT_EN
        // stuck-high gate times out once and does not retrigger
        s0 = n_start; e0 = n_end; t0 = n_to;
        raw = 1'b1; repeat (300) @(negedge clk);
        chk("t8_starts", n_start - s0, 1);
        chk("t8_ends", n_end - e0, 1);
        chk("t8_timeouts", n_to - t0, 1);
        chk("t8_len", spill_len, MAXL);
        chk("t8_in_spill", in_spill, 0);
        raw = 1'b0; repeat (30) @(negedge clk);
        chk("t8_no_retrigger", n_start - s0, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
